nv_nvdla_cdma_wt_rsp_pipe: RTL
==============================

NV_NVDLA_CDMA_WT_RSP_PIPE -- requirements
Module: nv_nvdla_cdma_wt_rsp_pipe

Interface
REQ-001 Parameter PW, 514, response payload width (512b data + 2b mask).
REQ-002 Parameter DEPTH, 4, total response storage entries including the output register; power of two, >= 2.
REQ-003 nvdla_core_clk  in  1  sole clock; all state on rising edge.
REQ-004 nvdla_core_rstn  in  1  reset; asynchronous assert, active-low.
REQ-005 rd_req_accept  in  1  one read request handshake completed this cycle (cv_dma_rd_req_vld && cv_dma_rd_req_rdy upstream).
REQ-006 rd_credit_avail  out  1  high when a further read request may be issued.
REQ-007 dma_rd_rsp_vld  in  1  response valid from DMA interface.
REQ-008 dma_rd_rsp_rdy  out  1  response ready to DMA interface.
REQ-009 dma_rd_rsp_pd  in  PW  response payload.
REQ-010 cv_int_rd_rsp_valid  out  1  response valid to weight unpacker.
REQ-011 cv_int_rd_rsp_ready  in  1  consumer ready.
REQ-012 cv_int_rd_rsp_pd  out  PW  response payload to consumer.
REQ-013 rd_outstanding  out  $clog2(DEPTH)+1  requests issued and not yet delivered to consumer.
REQ-014 rd_rsp_err  out  1  sticky protocol error flag (see Configuration).

Function
REQ-015 Storage: (DEPTH-1)-entry circular FIFO plus one output register driving cv_int_rd_rsp_pd/valid; pointers one bit wider than index for full/empty.
REQ-016 Input accept = dma_rd_rsp_vld && dma_rd_rsp_rdy; dma_rd_rsp_rdy = !(FIFO full && output register valid && !cv_int_rd_rsp_ready), combinational from registered state and consumer ready only.
REQ-017 Output handshake = cv_int_rd_rsp_valid && cv_int_rd_rsp_ready; payload held stable while valid && !ready.
REQ-018 Bypass: accepted response with FIFO empty and output register empty or popping this cycle loads output register directly; valid rises next cycle (1-cycle latency).
REQ-019 Otherwise accepted response writes FIFO tail; output register refills from FIFO head whenever empty or popping; order strictly preserved.
REQ-020 Simultaneous accept and pop with FIFO non-empty: head to output register, new data to tail, occupancy unchanged.
REQ-021 rd_outstanding: +1 on rd_req_accept, -1 on output handshake, unchanged when both, saturates at 0 and DEPTH.
REQ-022 rd_credit_avail = (rd_outstanding < DEPTH), registered-state only; guarantees responses never exceed storage.
REQ-023 Pointers wrap modulo DEPTH-1 index range with wrap bit toggling.

Reset
REQ-024 On rstn low: pointers 0, output valid 0, rd_outstanding 0, rd_credit_avail 1, dma_rd_rsp_rdy 1, rd_rsp_err 0; payload registers not reset.
REQ-025 Reset mid-operation discards all buffered responses and credits immediately; first post-reset accept behaves as from empty.

Configuration
REQ-026 Macro NVDLA_CDMA_WT_RSP_ERR_EN defined: rd_rsp_err sets and holds on rd_req_accept while rd_outstanding == DEPTH, or on input accept when responses stored >= rd_outstanding; cleared only by reset.
REQ-027 Macro undefined: error logic absent, rd_rsp_err tied 0; all other behaviour identical.

Structure
REQ-028 Shared package nv_nvdla_cdma_wt_pkg holds PW default, DEPTH default and the response payload typedef (data/mask fields).
REQ-029 FIFO storage and pointers form one sub-module nv_nvdla_cdma_wt_rsp_fifo; output register, credit counter and error logic stay in top.

Verification
REQ-030 Reset, 1 request, response 0xA5.. accepted cycle N, ready=1 -> valid at N+1 with pd 0xA5.., rd_outstanding 1->0 after handshake.
REQ-031 DEPTH=4, 4 requests, ready=0 -> rd_credit_avail 0 after 4th; 4 responses accepted, 5th cycle dma_rd_rsp_rdy=0.
REQ-032 Full, ready=1 and rsp_vld=1 same cycle -> one pop and one push, rdy stays 1, output order matches input sequence 1,2,3,4,5.
REQ-033 Random rsp_vld/ready over 1000 responses with wrap -> output sequence equals input sequence, no loss or duplication.
REQ-034 ERR_EN build: rd_req_accept at rd_outstanding=4 -> rd_rsp_err=1 next cycle and held; non-ERR_EN build -> stays 0.
REQ-035 Reset asserted with 3 buffered entries -> valid 0, rd_outstanding 0, rd_credit_avail 1 immediately; no stale data emitted after release.

Source files
------------

// File: rtl/nv_nvdla_cdma_wt_pkg.sv
// Shared types and defaults for the CDMA weight read-response pipe.
package nv_nvdla_cdma_wt_pkg;

  typedef struct packed {
    logic [511:0] data;
    logic [1:0]   mask;
  } wt_rsp_pd_t;

  localparam int WT_RSP_PW    = $bits(wt_rsp_pd_t);
  localparam int WT_RSP_DEPTH = 4;

endpackage

// File: rtl/nv_nvdla_cdma_wt_rsp_fifo.sv
// Circular response FIFO with wrap-bit pointers; depth need not be a power of two.
module nv_nvdla_cdma_wt_rsp_fifo
  import nv_nvdla_cdma_wt_pkg::*;
#(
  parameter int PW      = WT_RSP_PW,
  parameter int ENTRIES = WT_RSP_DEPTH - 1,
  parameter int CW      = $clog2(ENTRIES + 1) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [PW-1:0] push_pd,
  input  logic          pop,
  output logic [PW-1:0] head_pd,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [PW-1:0] mem [ENTRIES];
  logic [IW:0]   wr_ptr;
  logic [IW:0]   rd_ptr;

  // Index wraps at ENTRIES-1, toggling the top bit so full and empty stay distinct.
  function automatic logic [IW:0] ptr_inc(input logic [IW:0] p);
    if (p[IW-1:0] == IW'(ENTRIES - 1)) begin
      return {~p[IW], {IW{1'b0}}};
    end
    return p + (IW+1)'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= push_pd;
  end

  assign head_pd = mem[rd_ptr[IW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign count   = (wr_ptr[IW] == rd_ptr[IW])
                 ? CW'(wr_ptr[IW-1:0]) - CW'(rd_ptr[IW-1:0])
                 : CW'(ENTRIES) - CW'(rd_ptr[IW-1:0]) + CW'(wr_ptr[IW-1:0]);

endmodule

// File: rtl/nv_nvdla_cdma_wt_rsp_pipe.sv
// CDMA weight read-response pipe: FIFO + output register with credit tracking.
// Optional sticky protocol-error flag enabled by NVDLA_CDMA_WT_RSP_ERR_EN.
module nv_nvdla_cdma_wt_rsp_pipe
  import nv_nvdla_cdma_wt_pkg::*;
#(
  parameter int PW    = WT_RSP_PW,
  parameter int DEPTH = WT_RSP_DEPTH
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   rd_req_accept,
  output logic                   rd_credit_avail,
  input  logic                   dma_rd_rsp_vld,
  output logic                   dma_rd_rsp_rdy,
  input  logic [PW-1:0]          dma_rd_rsp_pd,
  output logic                   cv_int_rd_rsp_valid,
  input  logic                   cv_int_rd_rsp_ready,
  output logic [PW-1:0]          cv_int_rd_rsp_pd,
  output logic [$clog2(DEPTH):0] rd_outstanding,
  output logic                   rd_rsp_err
);

  localparam int OW = $clog2(DEPTH) + 1;

  logic          out_valid;
  logic [PW-1:0] out_pd;
  logic          out_pop;
  logic          out_free;
  logic          rsp_accept;
  logic          bypass;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW-1:0] fifo_head;
  logic [OW-1:0] fifo_count;

  assign out_pop    = out_valid && cv_int_rd_rsp_ready;
  assign out_free   = !out_valid || out_pop;
  assign dma_rd_rsp_rdy = !(fifo_full && out_valid && !cv_int_rd_rsp_ready);
  assign rsp_accept = dma_rd_rsp_vld && dma_rd_rsp_rdy;
  assign bypass     = rsp_accept && fifo_empty && out_free;
  assign fifo_push  = rsp_accept && !bypass;
  assign fifo_pop   = !fifo_empty && out_free;

  nv_nvdla_cdma_wt_rsp_fifo #(
    .PW      (PW),
    .ENTRIES (DEPTH - 1),
    .CW      (OW)
  ) u_fifo (
    .clk     (nvdla_core_clk),
    .rst_n   (nvdla_core_rstn),
    .push    (fifo_push),
    .push_pd (dma_rd_rsp_pd),
    .pop     (fifo_pop),
    .head_pd (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // FIFO head always has priority over bypass so ordering is preserved.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_valid <= 1'b0;
    end else if (fifo_pop || bypass) begin
      out_valid <= 1'b1;
    end else if (out_pop) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (fifo_pop) begin
      out_pd <= fifo_head;
    end else if (bypass) begin
      out_pd <= dma_rd_rsp_pd;
    end
  end

  assign cv_int_rd_rsp_valid = out_valid;
  assign cv_int_rd_rsp_pd    = out_pd;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rd_outstanding <= '0;
    end else if (rd_req_accept && !out_pop && rd_outstanding != OW'(DEPTH)) begin
      rd_outstanding <= rd_outstanding + OW'(1);
    end else if (out_pop && !rd_req_accept && rd_outstanding != '0) begin
      rd_outstanding <= rd_outstanding - OW'(1);
    end
  end

  assign rd_credit_avail = (rd_outstanding < OW'(DEPTH));

`ifdef NVDLA_CDMA_WT_RSP_ERR_EN
  logic [OW-1:0] stored;
  logic          err_q;

  // A response with nothing in flight, or a request beyond the credit limit, is a protocol error.
  assign stored = fifo_count + OW'(out_valid);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      err_q <= 1'b0;
    end else if ((rd_req_accept && rd_outstanding == OW'(DEPTH)) ||
                 (rsp_accept && stored >= rd_outstanding)) begin
      err_q <= 1'b1;
    end
  end

  assign rd_rsp_err = err_q;
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
  assign rd_rsp_err = 1'b0;
`endif

endmodule
